// File: rtl/trg_in_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// trg_in_ctrl_pkg
//  Shared constants for the trigger input front end: trigger source select
//  encodings, FSM state encodings and a helper that turns the programmed
//  minimum-width field into the effective filter threshold.
// ---------------------------------------------------------------------------
package trg_in_ctrl_pkg;

  // src_sel encodings: bit 0 enables the external path, bit 1 the software path
  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_EXT  = 2'b01;
  localparam logic [1:0] SRC_SW   = 2'b10;
  localparam logic [1:0] SRC_BOTH = 2'b11;

  // Acceptance FSM states
  localparam logic [0:0] ST_ARMED   = 1'b0;
  localparam logic [0:0] ST_HOLDOFF = 1'b1;

  // A programmed width of zero would never qualify, so it is treated as one
  function automatic logic [3:0] effWidth(input logic [3:0] width);
    return (width == 4'd0) ? 4'd1 : width;
  endfunction

endpackage

// File: rtl/trg_in_ctrl_if.sv
// ---------------------------------------------------------------------------
// trg_in_ctrl_if
//  Register-side bundle of the trigger front end: configuration written by
//  software and status/counters read back by it.
//   en_i        global trigger enable
//   src_sel_i   trigger source select (see trg_in_ctrl_pkg SRC_*)
//   min_width_i external filter width in cycles (0 behaves as 1)
//   holdoff_i   dead time after each accepted trigger, cycles
//   cnt_clr_i   synchronous clear of both counters
//   armed_o     front end armed and enabled
//   n_acc_o     saturating accepted-trigger count
//   n_rej_o     saturating rejected-trigger count
//  master = register block side, slave = trigger core side.
// ---------------------------------------------------------------------------
interface trg_in_ctrl_if #(
  parameter int HOLDOFF_W = 16,
  parameter int CNT_W     = 32
);
  logic                 en_i;
  logic [1:0]           src_sel_i;
  logic [3:0]           min_width_i;
  logic [HOLDOFF_W-1:0] holdoff_i;
  logic                 cnt_clr_i;
  logic                 armed_o;
  logic [CNT_W-1:0]     n_acc_o;
  logic [CNT_W-1:0]     n_rej_o;

  modport master (
    output en_i, src_sel_i, min_width_i, holdoff_i, cnt_clr_i,
    input  armed_o, n_acc_o, n_rej_o
  );

  modport slave (
    input  en_i, src_sel_i, min_width_i, holdoff_i, cnt_clr_i,
    output armed_o, n_acc_o, n_rej_o
  );
endinterface

// File: rtl/trg_in_ctrl_sync_filt.sv
// ---------------------------------------------------------------------------
// trg_in_ctrl_sync_filt
//  External trigger conditioning: synchroniser, polarity correction, minimum
//  width glitch filter and one-edge-per-pulse qualification.
//   clk_i        system clock
//   rst_i        asynchronous active-high reset
//   ext_trg_i    asynchronous external trigger level
//   ext_pol_i    1 = trigger is active-low
//   min_width_i  cycles the level must stay active before it qualifies
//   ext_q_o      registered 1-cycle pulse per qualified external trigger
// ---------------------------------------------------------------------------
module trg_in_ctrl_sync_filt
  import trg_in_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ext_trg_i,
  input  logic       ext_pol_i,
  input  logic [3:0] min_width_i,
  output logic       ext_q_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_syncVld;
  logic [3:0]             r_cnt;
  logic                   r_seenIdle;
  logic                   r_extQ;

  logic       w_sample;
  logic       w_vld;
  logic [3:0] w_cntNext;
  logic       w_qualify;

  // Synchroniser chain. r_syncVld marks when the chain holds real samples, so
  // the reset value of the flops is never mistaken for an inactive level (an
  // input held active through reset must not look like it went idle).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync    <= '0;
      r_syncVld <= '0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], ext_trg_i};
      r_syncVld <= {r_syncVld[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign w_sample  = r_sync[SYNC_STAGES-1] ^ ext_pol_i;
  assign w_vld     = r_syncVld[SYNC_STAGES-1];
  assign w_cntNext = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
  // Fires on the sample that brings the run length up to the threshold
  assign w_qualify = w_vld & w_sample & r_seenIdle & (w_cntNext == effWidth(min_width_i));

  // Width filter: count consecutive active samples, qualify once per pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt      <= '0;
      r_seenIdle <= 1'b0;
      r_extQ     <= 1'b0;
    end else begin
      r_extQ <= w_qualify;
      if (w_vld) begin
        if (w_sample) begin
          r_cnt <= w_cntNext;
          if (w_qualify) r_seenIdle <= 1'b0;
        end else begin
          r_cnt      <= '0;
          r_seenIdle <= 1'b1;
        end
      end
    end
  end

  assign ext_q_o = r_extQ;

endmodule

// File: rtl/trg_in_ctrl.sv
// ---------------------------------------------------------------------------
// trg_in_ctrl
//  Trigger front end: merges the conditioned external trigger with the
//  software trigger, applies enable/busy veto and a programmable hold-off,
//  emits a registered 1-cycle pulse per accepted trigger and keeps saturating
//  accepted/rejected counters.
//   clk_i      system clock
//   rst_i      asynchronous active-high reset
//   ext_trg_i  asynchronous external trigger level
//   ext_pol_i  1 = external trigger active-low
//   sw_trg_i   software trigger, 1-cycle pulse
//   busy_i     downstream busy veto
//   trg_o      accepted trigger pulse
//   regs       configuration / status bundle (trg_in_ctrl_if.slave)
// ---------------------------------------------------------------------------
module trg_in_ctrl
  import trg_in_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF_W   = 16,
  parameter int CNT_W       = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ext_trg_i,
  input  logic          ext_pol_i,
  input  logic          sw_trg_i,
  input  logic          busy_i,
  output logic          trg_o,
  trg_in_ctrl_if.slave  regs
);

  localparam logic [HOLDOFF_W-1:0] HOLD_ONE = {{(HOLDOFF_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]     CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic                 w_extQ;
  logic                 w_req;
  logic                 w_accept;
  logic                 w_reject;
  logic [0:0]           w_stateNext;
  logic [HOLDOFF_W-1:0] w_holdNext;

  logic [0:0]           r_state;
  logic [HOLDOFF_W-1:0] r_holdCnt;
  logic                 r_trg;
  logic                 r_armed;
  logic [CNT_W-1:0]     r_nAcc;
  logic [CNT_W-1:0]     r_nRej;

  trg_in_ctrl_sync_filt #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_syncFilt (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ext_trg_i   (ext_trg_i),
    .ext_pol_i   (ext_pol_i),
    .min_width_i (regs.min_width_i),
    .ext_q_o     (w_extQ)
  );

  // Coincident external and software requests collapse into a single request
  assign w_req    = (w_extQ & regs.src_sel_i[0]) | (sw_trg_i & regs.src_sel_i[1]);
  assign w_accept = w_req & regs.en_i & ~busy_i & (r_state == ST_ARMED);
  assign w_reject = w_req & regs.en_i & (busy_i | (r_state == ST_HOLDOFF));

  // Next-state logic: hold-off runs to completion regardless of en_i, and
  // returns to ARMED on the 1->0 step so the dead time is exactly holdoff_i.
  always_comb begin
    w_stateNext = r_state;
    w_holdNext  = r_holdCnt;
    case (r_state)
      ST_ARMED: begin
        if (w_accept && (regs.holdoff_i != '0)) begin
          w_stateNext = ST_HOLDOFF;
          w_holdNext  = regs.holdoff_i;
        end
      end
      default: begin
        w_holdNext = r_holdCnt - HOLD_ONE;
        if (r_holdCnt == HOLD_ONE) w_stateNext = ST_ARMED;
      end
    endcase
  end

  // FSM state, hold-off count and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_ARMED;
      r_holdCnt <= '0;
      r_trg     <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_holdCnt <= w_holdNext;
      r_trg     <= w_accept;
      r_armed   <= (w_stateNext == ST_ARMED) & regs.en_i;
    end
  end

  // Saturating counters; a clear wins over a same-cycle increment
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_nAcc <= '0;
      r_nRej <= '0;
    end else if (regs.cnt_clr_i) begin
      r_nAcc <= '0;
      r_nRej <= '0;
    end else begin
      if (w_accept && (r_nAcc != '1)) r_nAcc <= r_nAcc + CNT_ONE;
      if (w_reject && (r_nRej != '1)) r_nRej <= r_nRej + CNT_ONE;
    end
  end

  assign trg_o        = r_trg;
  assign regs.armed_o = r_armed;
  assign regs.n_acc_o = r_nAcc;
  assign regs.n_rej_o = r_nRej;

endmodule

// File: tb/tb_trg_in_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trg_in_ctrl
//  Directed bench for trg_in_ctrl: a table of single-cycle vectors with
//  hold-off disabled, followed by hand-written multi-cycle sequences for the
//  filter, hold-off, reset and saturation corners. Counters are built 4 bits
//  wide so saturation is reachable in a few cycles.
// ---------------------------------------------------------------------------
module tb_trg_in_ctrl;
  import trg_in_ctrl_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int HOLDOFF_W   = 16;
  localparam int CNT_W       = 4;

  typedef struct {
    logic       sw;
    logic       en;
    logic [1:0] src;
    logic       busy;
    logic       clr;
    logic       expTrg;
    logic       expArmed;
    logic [3:0] expAcc;
    logic [3:0] expRej;
  } vec_t;

  logic clk_i;
  logic rst_i;
  logic ext_trg_i;
  logic ext_pol_i;
  logic sw_trg_i;
  logic busy_i;
  logic trg_o;

  int nCompared;
  int nMismatched;

  vec_t vecs[12];

  trg_in_ctrl_if #(.HOLDOFF_W(HOLDOFF_W), .CNT_W(CNT_W)) regs();

  trg_in_ctrl #(
    .SYNC_STAGES (SYNC_STAGES),
    .HOLDOFF_W   (HOLDOFF_W),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .ext_trg_i (ext_trg_i),
    .ext_pol_i (ext_pol_i),
    .sw_trg_i  (sw_trg_i),
    .busy_i    (busy_i),
    .trg_o     (trg_o),
    .regs      (regs)
  );

  // 100 MHz clock
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Compare one observed value against its expected value
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance n clocks, leaving time 1 ns after the last rising edge
  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Drive one cycle of register/trigger inputs and clock it in
  task automatic applyStimulus(input logic sw, input logic en, input logic [1:0] src,
                               input logic busy, input logic clr);
    sw_trg_i       = sw;
    regs.en_i      = en;
    regs.src_sel_i = src;
    busy_i         = busy;
    regs.cnt_clr_i = clr;
    stepCycles(1);
    sw_trg_i       = 1'b0;
    regs.cnt_clr_i = 1'b0;
  endtask

  // Drive an active external pulse of 'width' clocks and watch a bounded
  // window; expLat=0 means no trigger is expected at all.
  task automatic extPulse(input string name, input int width, input int expLat);
    int count;
    int firstLat;
    count    = 0;
    firstLat = 0;
    ext_trg_i = ~ext_pol_i;
    for (int i = 1; i <= 20; i++) begin
      stepCycles(1);
      if (i == width) ext_trg_i = ext_pol_i;
      if (trg_o) begin
        count++;
        if (firstLat == 0) firstLat = i;
      end
    end
    checkOutput({name, " pulses"}, count, (expLat == 0) ? 0 : 1);
    if (expLat != 0) checkOutput({name, " latency"}, firstLat, expLat);
  endtask

  initial begin
    int acc0;
    nCompared   = 0;
    nMismatched = 0;

    // Reset-time values, checked before any clock edge
    rst_i            = 1'b1;
    ext_trg_i        = 1'b0;
    ext_pol_i        = 1'b0;
    sw_trg_i         = 1'b0;
    busy_i           = 1'b0;
    regs.en_i        = 1'b1;
    regs.src_sel_i   = SRC_SW;
    regs.min_width_i = 4'd4;
    regs.holdoff_i   = 16'd0;
    regs.cnt_clr_i   = 1'b0;
    #3;
    checkOutput("reset trg_o", trg_o, 0);
    checkOutput("reset armed_o", regs.armed_o, 0);
    checkOutput("reset n_acc", regs.n_acc_o, 0);
    checkOutput("reset n_rej", regs.n_rej_o, 0);
    stepCycles(1);
    rst_i = 1'b0;
    stepCycles(3);

    // Single-cycle vectors, hold-off 0 so the FSM stays ARMED
    vecs[0]  = '{1'b1, 1'b1, SRC_SW,   1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 4'd0};
    vecs[1]  = '{1'b1, 1'b1, SRC_SW,   1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 4'd0};
    vecs[2]  = '{1'b0, 1'b1, SRC_SW,   1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd0};
    vecs[3]  = '{1'b1, 1'b1, SRC_SW,   1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 4'd1};
    vecs[4]  = '{1'b1, 1'b0, SRC_SW,   1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd1};
    vecs[5]  = '{1'b1, 1'b1, SRC_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd1};
    vecs[6]  = '{1'b1, 1'b1, SRC_EXT,  1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd1};
    vecs[7]  = '{1'b1, 1'b1, SRC_BOTH, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 4'd1};
    vecs[8]  = '{1'b1, 1'b1, SRC_SW,   1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0};
    vecs[9]  = '{1'b1, 1'b0, SRC_SW,   1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
    vecs[10] = '{1'b1, 1'b1, SRC_BOTH, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1};
    vecs[11] = '{1'b0, 1'b1, SRC_SW,   1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1};
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].sw, vecs[i].en, vecs[i].src, vecs[i].busy, vecs[i].clr);
      checkOutput($sformatf("vec%0d trg_o", i), trg_o, vecs[i].expTrg);
      checkOutput($sformatf("vec%0d armed_o", i), regs.armed_o, vecs[i].expArmed);
      checkOutput($sformatf("vec%0d n_acc", i), regs.n_acc_o, vecs[i].expAcc);
      checkOutput($sformatf("vec%0d n_rej", i), regs.n_rej_o, vecs[i].expRej);
    end

    // Hold-off 10: sw at t=0 accepted, t=5 rejected, t=11 accepted again
    regs.holdoff_i = 16'd10;
    applyStimulus(1'b0, 1'b1, SRC_SW, 1'b0, 1'b1);
    for (int t = 0; t <= 12; t++) begin
      applyStimulus((t == 0) || (t == 5) || (t == 11), 1'b1, SRC_SW, 1'b0, 1'b0);
      checkOutput($sformatf("holdoff t%0d trg_o", t), trg_o, (t == 0) || (t == 11));
      if (t == 9)  checkOutput("holdoff armed_o t9", regs.armed_o, 0);
      if (t == 10) checkOutput("holdoff armed_o t10", regs.armed_o, 1);
    end
    checkOutput("holdoff n_acc", regs.n_acc_o, 2);
    checkOutput("holdoff n_rej", regs.n_rej_o, 1);

    // Asynchronous reset in the middle of a hold-off
    stepCycles(12);
    applyStimulus(1'b1, 1'b1, SRC_SW, 1'b0, 1'b0);
    checkOutput("pre-reset trg_o", trg_o, 1);
    rst_i = 1'b1;
    #2;
    checkOutput("async reset trg_o", trg_o, 0);
    checkOutput("async reset armed_o", regs.armed_o, 0);
    checkOutput("async reset n_acc", regs.n_acc_o, 0);
    #2;
    rst_i = 1'b0;
    stepCycles(2);
    checkOutput("post-reset armed_o", regs.armed_o, 1);
    applyStimulus(1'b1, 1'b1, SRC_SW, 1'b0, 1'b0);
    checkOutput("post-reset accept", trg_o, 1);

    // External path: width filter, latency and inverted polarity
    regs.holdoff_i   = 16'd0;
    regs.src_sel_i   = SRC_EXT;
    regs.min_width_i = 4'd4;
    stepCycles(3);
    extPulse("ext short", 3, 0);
    extPulse("ext long", 6, SYNC_STAGES + 4 + 1);
    ext_pol_i = 1'b1;
    ext_trg_i = 1'b1;
    stepCycles(6);
    extPulse("ext inverted", 6, SYNC_STAGES + 4 + 1);
    ext_pol_i = 1'b0;
    ext_trg_i = 1'b0;
    stepCycles(6);

    // External level held through reset never fires until seen idle
    ext_trg_i = 1'b1;
    rst_i     = 1'b1;
    stepCycles(1);
    rst_i = 1'b0;
    begin
      int count;
      count = 0;
      for (int i = 0; i < 20; i++) begin
        stepCycles(1);
        if (trg_o) count++;
      end
      checkOutput("ext held through reset", count, 0);
    end
    ext_trg_i = 1'b0;
    stepCycles(3);
    extPulse("ext after idle", 6, SYNC_STAGES + 4 + 1);

    // Coincident ext and sw requests with src=11 give one accept
    regs.src_sel_i = SRC_BOTH;
    applyStimulus(1'b0, 1'b1, SRC_BOTH, 1'b0, 1'b1);
    ext_trg_i = 1'b1;
    stepCycles(6);
    acc0 = int'(regs.n_acc_o);
    applyStimulus(1'b1, 1'b1, SRC_BOTH, 1'b0, 1'b0);
    checkOutput("ext+sw trg_o", trg_o, 1);
    checkOutput("ext+sw n_acc", regs.n_acc_o, acc0 + 1);
    ext_trg_i = 1'b0;
    stepCycles(1);
    checkOutput("ext+sw trg_o after", trg_o, 0);
    checkOutput("ext+sw n_acc after", regs.n_acc_o, acc0 + 1);

    // Saturation at all-ones and clear priority over a same-cycle accept
    applyStimulus(1'b0, 1'b1, SRC_SW, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b1, SRC_SW, 1'b0, 1'b0);
    checkOutput("sat n_acc 14", regs.n_acc_o, 14);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, SRC_SW, 1'b0, 1'b0);
    checkOutput("sat n_acc 15", regs.n_acc_o, 15);
    applyStimulus(1'b1, 1'b1, SRC_SW, 1'b0, 1'b1);
    checkOutput("clr with accept trg_o", trg_o, 1);
    checkOutput("clr with accept n_acc", regs.n_acc_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
